// File: rtl/load_store_unit.sv
// load_store_unit: bridges RISC-V byte/half/word loads and stores onto a
// word-only synchronous memory. Sub-word stores use read-modify-write.
module load_store_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned HW   = 16;
  localparam int unsigned BW   = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_MERGE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        size_q;
  logic [1:0]        off_q;
  logic [HW-1:0]     wd_q;
  logic [XLEN-1:0]   rd_q;

  logic              fault_c;
  logic [XLEN-1:0]   word_addr_c;
  logic [BW-1:0]     byte_c;
  logic [HW-1:0]     half_c;
  logic [XLEN-1:0]   load_val_c;
  logic [XLEN-1:0]   merged_c;

  assign word_addr_c = {core_addr_i[31:2], 2'b00};

  // Illegal size or misaligned address detection for the incoming request
  always_comb begin
    fault_c = 1'b0;
    case (core_size_i)
      3'b000, 3'b100: fault_c = 1'b0;
      3'b001, 3'b101: fault_c = core_addr_i[0];
      3'b010:         fault_c = |core_addr_i[1:0];
      default:        fault_c = 1'b1;
    endcase
    if (core_we_i && core_size_i[2]) fault_c = 1'b1;
  end

  // Load lane selection/extension and store merge into the old word
  always_comb begin
    byte_c     = mem_rd_i[7:0];
    half_c     = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    load_val_c = mem_rd_i;
    merged_c   = mem_rd_i;
    case (off_q)
      2'd0: byte_c = mem_rd_i[7:0];
      2'd1: byte_c = mem_rd_i[15:8];
      2'd2: byte_c = mem_rd_i[23:16];
      default: byte_c = mem_rd_i[31:24];
    endcase
    case (size_q)
      3'b000:  load_val_c = {{(XLEN-BW){byte_c[BW-1]}}, byte_c};
      3'b100:  load_val_c = {{(XLEN-BW){1'b0}}, byte_c};
      3'b001:  load_val_c = {{(XLEN-HW){half_c[HW-1]}}, half_c};
      3'b101:  load_val_c = {{(XLEN-HW){1'b0}}, half_c};
      default: load_val_c = mem_rd_i;
    endcase
    if (size_q[0]) begin
      if (off_q[1]) merged_c[31:16] = wd_q;
      else          merged_c[15:0]  = wd_q;
    end else begin
      case (off_q)
        2'd0: merged_c[7:0]   = wd_q[BW-1:0];
        2'd1: merged_c[15:8]  = wd_q[BW-1:0];
        2'd2: merged_c[23:16] = wd_q[BW-1:0];
        default: merged_c[31:24] = wd_q[BW-1:0];
      endcase
    end
  end

  // Next-state and memory/core handshake outputs
  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wd_o     = '0;
    core_stall_o = 1'b0;
    core_fault_o = 1'b0;
    core_rd_o    = rd_q;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          if (fault_c) begin
            core_fault_o = 1'b1;
          end else begin
            mem_req_o  = 1'b1;
            mem_addr_o = word_addr_c;
            if (core_we_i) begin
              if (core_size_i[1]) begin
                mem_we_o = 1'b1;
                mem_wd_o = core_wd_i;
              end else begin
                core_stall_o = 1'b1;
                state_d      = RMW_MERGE;
              end
            end else begin
              core_stall_o = 1'b1;
              state_d      = LOAD_WAIT;
            end
          end
        end
      end
      LOAD_WAIT: begin
        core_rd_o = load_val_c;
        state_d   = IDLE;
      end
      RMW_MERGE: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = word_addr_c;
        mem_wd_o   = merged_c;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset suppresses any memory access, including an in-flight merge write
    if (rst_i) begin
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      core_stall_o = 1'b0;
      core_fault_o = 1'b0;
    end
  end

  // State, issue-time latches and load hold register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      size_q  <= '0;
      off_q   <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && core_req_i) begin
        size_q <= core_size_i;
        off_q  <= core_addr_i[1:0];
        wd_q   <= core_wd_i[HW-1:0];
      end
      if (state_q == LOAD_WAIT) rd_q <= load_val_c;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  size = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] core_rd;
  logic        stall, fault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wd;
  logic [31:0] mem_rd = '0;

  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  logic [31:0] mem [0:255];
  int          writes = 0;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rd = '0;

  load_store_unit dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(req), .core_we_i(we), .core_size_i(size),
    .core_addr_i(addr), .core_wd_i(wd), .core_rd_o(core_rd),
    .core_stall_o(stall), .core_fault_o(fault),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
  );

  always #5 clk = ~clk;

  // Synchronous word memory: read data one cycle after request
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_req) begin
      if (mem_we) begin
        mem[mem_addr[9:2]] <= mem_wd;
        writes <= writes + 1;
      end else begin
        mem_rd <= mem[mem_addr[9:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = a[9:2]; pre_val = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    #1;
    check("idle_req", 32'(mem_req), 32'd0);
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_fault", 32'(fault), 32'd0);
    check("idle_rd_hold", core_rd, exp_rd);
  endtask

  task automatic do_load(input logic [2:0] s, input logic [31:0] a, input logic [31:0] e);
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = s; addr = a; wd = '0;
    #1;
    check("ld_issue_stall", 32'(stall), 32'd1);
    check("ld_issue_req", 32'(mem_req), 32'd1);
    check("ld_issue_we", 32'(mem_we), 32'd0);
    check("ld_issue_addr", mem_addr, {a[31:2], 2'b00});
    @(negedge clk);
    #1;
    check("ld_done_stall", 32'(stall), 32'd0);
    check("ld_done_req", 32'(mem_req), 32'd0);
    check("ld_data", core_rd, e);
    exp_rd = e;
  endtask

  task automatic do_sw(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 3'b010; addr = a; wd = d;
    #1;
    check("sw_req", 32'(mem_req), 32'd1);
    check("sw_we", 32'(mem_we), 32'd1);
    check("sw_stall", 32'(stall), 32'd0);
    check("sw_wd", mem_wd, d);
  endtask

  task automatic do_sub_store(input logic [2:0] s, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] merged);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = s; addr = a; wd = d;
    #1;
    check("rmw_rd_req", 32'(mem_req), 32'd1);
    check("rmw_rd_we", 32'(mem_we), 32'd0);
    check("rmw_rd_stall", 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    check("rmw_wr_req", 32'(mem_req), 32'd1);
    check("rmw_wr_we", 32'(mem_we), 32'd1);
    check("rmw_wr_stall", 32'(stall), 32'd0);
    check("rmw_wr_data", mem_wd, merged);
  endtask

  task automatic do_fault(input logic w, input logic [2:0] s, input logic [31:0] a);
    @(negedge clk);
    req = 1'b1; we = w; size = s; addr = a; wd = 32'hDEAD_BEEF;
    #1;
    check("flt_pulse", 32'(fault), 32'd1);
    check("flt_req", 32'(mem_req), 32'd0);
    check("flt_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int wr0;
    // reset with a request pending: handshake outputs forced low
    req = 1'b1; we = 1'b1; size = 3'b010; addr = 32'h100;
    @(negedge clk);
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rd", core_rd, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wd", mem_wd, 32'd0);

    preload(32'h100, 32'h8081_7F02);
    do_load(3'b000, 32'h102, 32'hFFFF_FF81); idle();
    do_load(3'b100, 32'h102, 32'h0000_0081); idle();
    do_load(3'b001, 32'h102, 32'hFFFF_8081); idle();
    do_load(3'b101, 32'h100, 32'h0000_7F02); idle();

    do_sw(32'h200, 32'hCAFE_BABE); idle();
    check("sw_mem", mem[8'h80], 32'hCAFE_BABE);
    do_load(3'b010, 32'h200, 32'hCAFE_BABE); idle();

    do_sub_store(3'b000, 32'h101, 32'h0000_00AA, 32'h8081_AA02); idle();
    check("sb_mem", mem[8'h40], 32'h8081_AA02);
    do_sub_store(3'b001, 32'h102, 32'h0000_1234, 32'h1234_AA02); idle();
    check("sh_mem", mem[8'h40], 32'h1234_AA02);

    wr0 = writes;
    do_fault(1'b0, 3'b010, 32'h103); idle();
    do_fault(1'b1, 3'b001, 32'h101); idle();
    do_fault(1'b1, 3'b100, 32'h100); idle();
    do_fault(1'b0, 3'b011, 32'h100); idle();
    check("flt_nowrite", 32'(writes - wr0), 32'd0);
    check("flt_mem", mem[8'h40], 32'h1234_AA02);

    // reset while the merge write is pending
    preload(32'h100, 32'h8081_7F02);
    wr0 = writes;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 3'b000; addr = 32'h100; wd = 32'h55;
    #1;
    check("rrst_issue_stall", 32'(stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rrst_req", 32'(mem_req), 32'd0);
    check("rrst_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0; we = 1'b0;
    exp_rd = '0;
    #1;
    check("rrst_rd", core_rd, 32'd0);
    check("rrst_nowrite", 32'(writes - wr0), 32'd0);
    check("rrst_mem", mem[8'h40], 32'h8081_7F02);
    idle();

    // back-to-back LB, SW, LHU
    do_load(3'b000, 32'h102, 32'hFFFF_FF81);
    do_sw(32'h204, 32'h1122_3344);
    do_load(3'b101, 32'h206, 32'h0000_1122);
    idle();
    check("b2b_mem", mem[8'h81], 32'h1122_3344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
